// File: rtl/trap_ctrl_pkg.sv
// Shared constants, types and helpers for the machine-mode trap sequencer.
// Covers CSR addresses, interrupt bit positions, cause codes and FSM states.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int unsigned BIT_MEI      = 11;
    localparam int unsigned BIT_MTI      = 7;
    localparam int unsigned BIT_MSI      = 3;
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [31:0] CAUSE_ECALL_M = 32'h0000_000B;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_REDIR
    } state_t;

    typedef enum logic [1:0] {
        TMR_CMP_LO  = 2'd0,
        TMR_CMP_HI  = 2'd1,
        TMR_TIME_LO = 2'd2,
        TMR_TIME_HI = 2'd3
    } tmr_sel_t;

    // Fixed priority among pending-and-enabled interrupts: MEI > MSI > MTI.
    function automatic logic [31:0] irq_cause(input logic [31:0] pend);
        logic [31:0] c;
        if (pend[BIT_MEI])      c = CAUSE_MEI;
        else if (pend[BIT_MSI]) c = CAUSE_MSI;
        else                    c = CAUSE_MTI;
        return c;
    endfunction

    // mtvec==0 falls back to the boot vector; vectored mode only for interrupts.
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic [31:0] cause,
                                                input logic [31:0] boot);
        logic [31:0] base;
        base = (tvec == 32'h0) ? boot : {tvec[31:2], 2'b00};
        if (tvec[0] && cause[31])
            base = base + {26'h0, cause[3:0], 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/trap_timer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp and registered MTIP compare.
module trap_timer
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tmr_we,
    input  logic [1:0]  tmr_sel,
    input  logic [31:0] tmr_wdata,
    output logic [63:0] mtime,
    output logic        mtip
);

    localparam logic [7:0] PRE_LAST = 8'(TIMER_DIV - 1);

    logic [7:0]  pre_q;
    logic [63:0] time_q;
    logic [63:0] cmp_q;
    logic        mtip_q;
    logic        tick;
    logic        time_wr;

    assign tick    = (pre_q == PRE_LAST);
    assign time_wr = tmr_we && ((tmr_sel == TMR_TIME_LO) || (tmr_sel == TMR_TIME_HI));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            time_q <= '0;
            cmp_q  <= '1;
            mtip_q <= 1'b0;
        end else begin
            pre_q  <= tick ? '0 : pre_q + 8'd1;
            mtip_q <= (time_q >= cmp_q);

            if (tmr_we && (tmr_sel == TMR_CMP_LO)) cmp_q[31:0]  <= tmr_wdata;
            if (tmr_we && (tmr_sel == TMR_CMP_HI)) cmp_q[63:32] <= tmr_wdata;

            // A software time write overrides the pending increment.
            if (time_wr) begin
                if (tmr_sel == TMR_TIME_HI) time_q[63:32] <= tmr_wdata;
                else                        time_q[31:0]  <= tmr_wdata;
            end else if (tick) begin
                time_q <= time_q + 64'd1;
            end
        end
    end

    assign mtime = time_q;
    assign mtip  = mtip_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: owns MIE/MPIE, mie, mip and the timer,
// decides trap entry or MRET at retirement and holds a fetch redirect until ack.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT      = 32'h0000_0000,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic [31:0] retire_npc,
    input  logic [31:0] retire_pc,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        tmr_we,
    input  logic [1:0]  tmr_sel,
    input  logic [31:0] tmr_wdata,
    output logic [63:0] mtime,
    output logic        mepc_we,
    output logic        mcause_we,
    output logic [31:0] mepc_wdata,
    output logic [31:0] mcause_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        st_mie_q, st_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] epc_q, cause_q;
    logic [31:0] redir_q;
    logic [31:0] rdata_q, rdata_d;
    logic        mtip;
    logic [31:0] mip_w;
    logic [31:0] pend;
    logic        irq_take;

    logic        do_mret, do_trap, do_enter;
    logic [31:0] trap_epc, trap_cause;

    trap_timer #(
        .TIMER_DIV(TIMER_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tmr_we   (tmr_we),
        .tmr_sel  (tmr_sel),
        .tmr_wdata(tmr_wdata),
        .mtime    (mtime),
        .mtip     (mtip)
    );

    always_comb begin
        mip_w          = '0;
        mip_w[BIT_MEI] = irq_ext;
        mip_w[BIT_MTI] = mtip;
        mip_w[BIT_MSI] = irq_sw;
    end

    assign pend     = mip_w & mie_q;
    assign irq_take = st_mie_q && (|pend);

    always_comb begin
        state_d    = state_q;
        do_mret    = 1'b0;
        do_trap    = 1'b0;
        do_enter   = 1'b0;
        trap_epc   = '0;
        trap_cause = '0;
        case (state_q)
            ST_IDLE: begin
                if (retire_valid) begin
                    if (is_mret) begin
                        do_mret = 1'b1;
                        state_d = ST_REDIR;
                    end else if (is_ecall) begin
                        do_trap    = 1'b1;
                        trap_epc   = retire_pc;
                        trap_cause = CAUSE_ECALL_M;
                        state_d    = ST_ENTER;
                    end else if (irq_take) begin
                        do_trap    = 1'b1;
                        trap_epc   = retire_npc;
                        trap_cause = irq_cause(pend);
                        state_d    = ST_ENTER;
                    end
                end
            end
            ST_ENTER: begin
                do_enter = 1'b1;
                state_d  = ST_REDIR;
            end
            ST_REDIR: begin
                if (redirect_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                rdata_d[MSTATUS_MIE]  = st_mie_q;
                rdata_d[MSTATUS_MPIE] = st_mpie_q;
            end
            CSR_MIE: rdata_d = mie_q;
            CSR_MIP: rdata_d = mip_w;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            st_mie_q  <= 1'b0;
            st_mpie_q <= 1'b0;
            mie_q     <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            redir_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;

            if (csr_we && (csr_addr == CSR_MIE))
                mie_q <= csr_wdata & IRQ_MASK;

            if (do_trap) begin
                epc_q   <= trap_epc;
                cause_q <= trap_cause;
            end

            // FSM-driven MIE/MPIE updates take precedence; software writes to
            // mstatus only land while idle.
            if (do_mret) begin
                st_mie_q  <= st_mpie_q;
                st_mpie_q <= 1'b1;
                redir_q   <= mepc;
            end else if (do_enter) begin
                st_mpie_q <= st_mie_q;
                st_mie_q  <= 1'b0;
                redir_q   <= trap_target(mtvec, cause_q, BOOT);
            end else if (csr_we && (csr_addr == CSR_MSTATUS) && (state_q == ST_IDLE)) begin
                st_mie_q  <= csr_wdata[MSTATUS_MIE];
                st_mpie_q <= csr_wdata[MSTATUS_MPIE];
            end
        end
    end

    assign csr_rdata      = rdata_q;
    assign mepc_we        = (state_q == ST_ENTER);
    assign mcause_we      = (state_q == ST_ENTER);
    assign mepc_wdata     = epc_q;
    assign mcause_wdata   = cause_q;
    assign redirect_valid = (state_q == ST_REDIR);
    assign redirect_pc    = redir_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized
// retire/interrupt/CSR traffic against a transaction-level model.
module tb_trap_ctrl;

    localparam logic [31:0] BOOT_PC = 32'h0000_0800;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_npc = '0, retire_pc = '0;
    logic        is_ecall = 1'b0, is_mret = 1'b0;
    logic        irq_ext = 1'b0, irq_sw = 1'b0;
    logic [31:0] mtvec = '0, mepc = '0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        tmr_we = 1'b0;
    logic [1:0]  tmr_sel = '0;
    logic [31:0] tmr_wdata = '0;
    logic [63:0] mtime;
    logic        mepc_we, mcause_we;
    logic [31:0] mepc_wdata, mcause_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack = 1'b0;
    logic        busy;

    trap_ctrl #(
        .BOOT     (BOOT_PC),
        .TIMER_DIV(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .retire_valid  (retire_valid),
        .retire_npc    (retire_npc),
        .retire_pc     (retire_pc),
        .is_ecall      (is_ecall),
        .is_mret       (is_mret),
        .irq_ext       (irq_ext),
        .irq_sw        (irq_sw),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .tmr_we        (tmr_we),
        .tmr_sel       (tmr_sel),
        .tmr_wdata     (tmr_wdata),
        .mtime         (mtime),
        .mepc_we       (mepc_we),
        .mcause_we     (mcause_we),
        .mepc_wdata    (mepc_wdata),
        .mcause_wdata  (mcause_wdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ack  (redirect_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    // Architectural model state
    logic        m_mie = 1'b0, m_mpie = 1'b0, m_mtip = 1'b0;
    logic [31:0] m_iemask = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        tick();
        d = csr_rdata;
    endtask

    task automatic tmr_wr(input logic [1:0] s, input logic [31:0] d);
        tmr_we = 1'b1; tmr_sel = s; tmr_wdata = d;
        tick();
        tmr_we = 1'b0;
    endtask

    task automatic set_cmp(input logic big);
        tmr_wr(2'd1, big ? 32'hFFFF_FFFF : 32'h0);
        tmr_wr(2'd0, big ? 32'hFFFF_FFFF : 32'h0);
        tick();
        m_mtip = !big;
    endtask

    function automatic logic [31:0] target_of(input logic [31:0] tv, input logic [31:0] c);
        logic [31:0] t;
        if (tv == 0) t = BOOT_PC;
        else         t = (tv / 4) * 4;
        if ((tv % 2 == 1) && (c >= 32'h8000_0000)) t = t + 4 * (c % 16);
        return t;
    endfunction

    function automatic logic [31:0] mstatus_of();
        return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
    endfunction

    task automatic run_retire(input logic [31:0] pc, input logic [31:0] npc,
                              input logic ecall, input logic mret);
        logic        ext_p, sw_p, tm_p, trap;
        logic [31:0] cause, epc, tgt;
        int unsigned hold;
        ext_p = irq_ext && m_iemask[11];
        sw_p  = irq_sw  && m_iemask[3];
        tm_p  = m_mtip  && m_iemask[7];
        trap  = !mret && (ecall || (m_mie && (ext_p || sw_p || tm_p)));
        epc   = ecall ? pc : npc;
        if (ecall)      cause = 32'h0000_000B;
        else if (ext_p) cause = 32'h8000_000B;
        else if (sw_p)  cause = 32'h8000_0003;
        else            cause = 32'h8000_0007;
        tgt = mret ? mepc : target_of(mtvec, cause);

        retire_valid = 1'b1; retire_pc = pc; retire_npc = npc;
        is_ecall = ecall; is_mret = mret;
        tick();
        retire_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;

        if (mret) begin
            chk("mret_redir_lat", redirect_valid, 1);
            chk("mret_no_strobe", mepc_we, 0);
            chk("mret_pc", redirect_pc, tgt);
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end else if (trap) begin
            chk("enter_redir_early", redirect_valid, 0);
            chk("enter_mepc_we", mepc_we, 1);
            chk("enter_mcause_we", mcause_we, 1);
            chk("enter_mepc", mepc_wdata, epc);
            chk("enter_mcause", mcause_wdata, cause);
            tick();
            chk("trap_redir_lat", redirect_valid, 1);
            chk("trap_strobe_once", mepc_we, 0);
            chk("trap_pc", redirect_pc, tgt);
            m_mpie = m_mie;
            m_mie  = 1'b0;
        end else begin
            chk("noop_busy", busy, 0);
            chk("noop_redir", redirect_valid, 0);
            return;
        end

        // mstatus writes while the sequencer is busy must have no effect
        csr_wr(A_MSTATUS, $urandom);
        chk("hold_valid", redirect_valid, 1);
        chk("hold_pc", redirect_pc, tgt);
        hold = $urandom_range(0, 2);
        for (int unsigned i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", redirect_valid, 1);
            chk("hold_pc", redirect_pc, tgt);
        end
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        chk("ack_drop", redirect_valid, 0);
        chk("ack_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, w;
        logic        big;
        int unsigned kind, tsel;
        bit          done;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_redir", redirect_valid, 0);
        chk("rst_strobe", mepc_we | mcause_we, 0);
        chk("rst_rdata", csr_rdata, 0);
        chk("rst_mtime", mtime, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mtime_0", mtime, 0);
        tick(); chk("mtime_1", mtime, 1);
        tick(); chk("mtime_2", mtime, 2);
        csr_rd(A_MIE, rd);     chk("rst_mie", rd, 0);
        csr_rd(A_MSTATUS, rd); chk("rst_mstatus", rd, 0);
        csr_rd(A_MIP, rd);     chk("rst_mip", rd, 0);
        csr_rd(12'h305, rd);   chk("unmapped_rd", rd, 0);

        // Time writes drop the increment; 64-bit wrap-around
        tmr_wr(2'd3, 32'hFFFF_FFFF);
        tmr_wr(2'd2, 32'hFFFF_FFFF);
        chk("time_wr_wins", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("time_wrap", mtime, 0);
        tmr_wr(2'd2, 32'h1000);
        chk("time_lo_wr", mtime, 64'h1000);
        tick();
        chk("time_inc", mtime, 64'h1001);

        // ECALL entry
        csr_wr(A_MSTATUS, 32'h8); m_mie = 1'b1;
        mtvec = 32'h200;
        run_retire(32'h100, 32'h104, 1'b1, 1'b0);
        csr_rd(A_MSTATUS, rd); chk("ecall_mstatus", rd, mstatus_of());

        // MRET
        mepc = 32'h104;
        run_retire(32'h300, 32'h304, 1'b0, 1'b1);
        csr_rd(A_MSTATUS, rd); chk("mret_mstatus", rd, mstatus_of());

        // Timer interrupt
        csr_wr(A_MIE, 32'h80); m_iemask = 32'h80;
        tmr_wr(2'd2, 32'h0);
        tmr_wr(2'd1, 32'h0);
        tmr_wr(2'd0, 32'h20);
        done = 1'b0;
        for (int unsigned i = 0; i < 200 && !done; i++) begin
            if (mtime >= 64'h21) done = 1'b1;
            else tick();
        end
        chk("mtip_wait", done, 1);
        tick();
        m_mtip = 1'b1;
        csr_rd(A_MIP, rd); chk("mip_mtip", rd, 32'h80);
        run_retire(32'h40, 32'h44, 1'b0, 1'b0);
        set_cmp(1'b1);

        // Simultaneous ext+sw, vectored
        csr_wr(A_MSTATUS, 32'h8); m_mie = 1'b1; m_mpie = 1'b0;
        csr_wr(A_MIE, 32'hFFFF_FFFF); m_iemask = 32'h888;
        irq_ext = 1'b1; irq_sw = 1'b1;
        mtvec = 32'h301;
        run_retire(32'h80, 32'h84, 1'b0, 1'b0);
        irq_ext = 1'b0; irq_sw = 1'b0;

        // Randomized traffic
        for (int unsigned it = 0; it < 40; it++) begin
            irq_ext = 1'($urandom_range(0, 1));
            irq_sw  = 1'($urandom_range(0, 1));
            big     = 1'($urandom_range(0, 1));
            set_cmp(big);
            w = $urandom; csr_wr(A_MIE, w); m_iemask = w & 32'h888;
            w = $urandom; csr_wr(A_MSTATUS, w); m_mie = w[3]; m_mpie = w[7];
            csr_rd(A_MIE, rd);     chk("rnd_mie", rd, m_iemask);
            csr_rd(A_MSTATUS, rd); chk("rnd_mstatus", rd, mstatus_of());
            csr_rd(A_MIP, rd);
            chk("rnd_mip", rd, (irq_ext ? 32'h800 : 0) | (m_mtip ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0));
            tsel = $urandom_range(0, 3);
            w = $urandom;
            if (tsel == 0)      mtvec = 32'h0;
            else if (tsel == 1) mtvec = w & 32'hFFFF_FFFE;
            else                mtvec = w | 32'h1;
            mepc = $urandom;
            w = $urandom;
            kind = $urandom_range(0, 7);
            run_retire(w, w + 4, kind inside {[2:5]}, kind inside {[0:1], [4:5]});
            csr_rd(A_MSTATUS, rd); chk("rnd_post_mstatus", rd, mstatus_of());
        end
        irq_ext = 1'b0; irq_sw = 1'b0;

        // Reset while a redirect is outstanding
        set_cmp(1'b0);
        csr_wr(A_MSTATUS, 32'h8);
        mtvec = 32'h400;
        retire_valid = 1'b1; is_ecall = 1'b1; retire_pc = 32'h500;
        tick();
        retire_valid = 1'b0; is_ecall = 1'b0;
        tick();
        chk("pre_rst_redir", redirect_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_redir", redirect_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_strobe", mepc_we | mcause_we | redirect_valid, 0);
        end
        m_mie = 1'b0; m_mpie = 1'b0; m_iemask = '0; m_mtip = 1'b0;
        csr_rd(A_MIP, rd);     chk("post_rst_mip", rd, 0);
        csr_rd(A_MSTATUS, rd); chk("post_rst_mstatus", rd, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap/interrupt sequencer beside the CSR file.
- Owns mstatus.MIE/MPIE, mie, mip, the 64-bit machine timer (mtime/mtimecmp) and interrupt priority arbitration.
- At instruction retirement it decides trap entry (ECALL or interrupt) or MRET, issues the mepc/mcause write strobes to the CSR file, and holds a redirect request to the fetch stage until acknowledged.

Parameters:
- BOOT, 32'h00000000, redirect target used when mtvec is unusable (mtvec==0).
- TIMER_DIV, 1, mtime increments once every TIMER_DIV cycles (1..256).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- retire_valid  in  1  an instruction retires this cycle
- retire_npc  in  32  PC of the next instruction that would execute
- retire_pc  in  32  PC of the retiring instruction
- is_ecall  in  1  retiring instruction is ECALL (valid with retire_valid)
- is_mret  in  1  retiring instruction is MRET (valid with retire_valid)
- irq_ext  in  1  level external interrupt (MEIP)
- irq_sw  in  1  level software interrupt (MSIP)
- mtvec  in  32  from CSR file
- mepc  in  32  from CSR file
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address (0x300 mstatus, 0x304 mie, 0x344 mip)
- csr_wdata  in  32  already-resolved write value
- csr_rdata  out  32  registered read of mstatus/mie/mip; 0 otherwise
- tmr_we  in  1  timer register write
- tmr_sel  in  2  0 cmp_lo, 1 cmp_hi, 2 time_lo, 3 time_hi
- tmr_wdata  in  32  timer write data
- mtime  out  64  current timer value
- mepc_we, mcause_we  out  1  one-cycle strobes to CSR file
- mepc_wdata, mcause_wdata  out  32  values for those strobes
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  target; stable while redirect_valid
- redirect_ack  in  1  fetch accepted redirect
- busy  out  1  high in any state but IDLE; core stalls retirement

Behaviour:
- Reset (rst low, async): FSM=IDLE; MIE=0, MPIE=0, mie=0; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; all strobes, redirect_valid, busy and csr_rdata = 0.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; mtime+=1 on wrap, with 64-bit wrap-around.
  - tmr_we writes the selected 32-bit half.
  - A time write in the same cycle as an increment wins; the increment is dropped.
- mip (read-only): MEIP=bit11 (irq_ext), MTIP=bit7 (registered mtime>=mtimecmp, unsigned), MSIP=bit3 (irq_sw).
- mstatus: bit3 MIE, bit7 MPIE, all other bits read 0.
- mie: bits 11/7/3 writable, all others 0.
- CSR writes take effect next cycle.
- Interrupt take condition: MIE & |(mip & mie). Priority MEI > MSI > MTI; cause = 0x8000000B / 0x80000003 / 0x80000007.
- FSM states:
  - IDLE: evaluated only when retire_valid.
    - is_mret: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc, go REDIR.
    - Else is_ecall: epc=retire_pc, cause=0x0000000B, go ENTER.
    - Else interrupt taken: epc=retire_npc, cause per priority, go ENTER. The retiring instruction completes first.
    - ECALL outranks a simultaneous interrupt; the interrupt stays pending.
  - ENTER (1 cycle):
    - Pulse mepc_we/mcause_we with latched values; MPIE<=MIE, MIE<=0.
    - base = mtvec&~3, or BOOT if mtvec==0. If mtvec[0]==1 and cause is an interrupt, redirect_pc = base + 4*cause[3:0]; otherwise base.
    - Go REDIR.
  - REDIR: redirect_valid=1, busy=1; stay until redirect_ack, then IDLE (redirect_valid drops the next cycle).
- A csr_we to mstatus while not IDLE is ignored, because the FSM owns MIE/MPIE there.
- Latency: retire to redirect_valid is 2 cycles for trap entry, 1 cycle for MRET.
- Reset mid-sequence returns to IDLE immediately; no strobe is emitted after reset assertion.

Decomposition:
- Shared package/include: CSR address constants, cause codes, mip/mie bit positions, FSM state encodings.
- One natural sub-module: trap_timer (prescaler, mtime, mtimecmp, MTIP compare).

Test Plan:
- Reset, then read 0x304/0x300 -> 0; mtime counts 0,1,2 with TIMER_DIV=1; cmp reads all ones; MTIP=0.
- ECALL at retire_pc=0x100, mtvec=0x200 -> ENTER strobes mepc=0x100, mcause=0xB; redirect_pc=0x200 held 3 cycles until ack; MIE 1→0, MPIE←1.
- Timer: set cmp=0x20, mie.MTIE=1, MIE=1; retire at npc=0x44 once mtime>=0x20 -> mcause=0x80000007, mepc=0x44.
- irq_ext and irq_sw both asserted, vectored mtvec=0x301 -> mcause=0x8000000B, redirect_pc=0x32C.
- MRET with mepc=0x104, MPIE=1 -> redirect_pc=0x104 after 1 cycle; MIE=1, MPIE=1.
- Assert rst low while in REDIR -> redirect_valid=0 immediately; no mepc_we after release; mtimecmp restored to all ones.
